counter_checker: RTL and testbench

//  Receive-side monitor for the free-running up-counter: samples the counter's value bus every clk,

---
 rtl/counter_checker.sv | 183 ++++++++++++++++++
 tb/tb_counter_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//   Receive-side monitor for a free-running up-counter. Samples the counter's
//   value every clock, predicts the next value (value + 1, wrapping), and flags
//   skips, stalls or wrong reset values once it has locked onto the sequence.
//   The counter's own synchronous reset is observed so that clears are not
//   reported as errors.
//
// Parameters
//   WIDTH      width of the observed counter value
//   ERR_CNT_W  width of the saturating error counter
//   SYNC_LEN   consecutive correct samples needed to declare lock (1..15)
//
// Ports
//   clk_i        clock, all sampling on the rising edge
//   rst_ni       asynchronous active-low reset, clears all checker state
//   value_i      counter value under observation
//   dut_reset_i  counter's active-high reset, sampled on clk_i
//   locked_o     1 while the prediction tracks the counter
//   err_o        one-cycle pulse per mismatch detected while locked
//   err_count_o  saturating mismatch count
//   expected_o   predicted value for the next sample
//
// Optional feature (macro COUNTER_CHECK_CAPTURE_EN)
//   Adds first_err_valid_o / first_err_exp_o / first_err_obs_o, which capture
//   the expected and observed values of the first error seen while locked.
//   The capture is sticky until rst_ni.
// -----------------------------------------------------------------------------
module counter_checker #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 16,
    parameter int SYNC_LEN  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     value_i,
    input  logic                 dut_reset_i,
`ifdef COUNTER_CHECK_CAPTURE_EN
    output logic                 first_err_valid_o,
    output logic [WIDTH-1:0]     first_err_exp_o,
    output logic [WIDTH-1:0]     first_err_obs_o,
`endif
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic [WIDTH-1:0]     expected_o
);

    // SYNC_LEN tops out at 15, so four bits always hold the run length.
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    // State after a mismatch restarts the run at 1: with SYNC_LEN==1 a single
    // correct sample is already a full run, so lock is kept.
    localparam state_e RESTART_ST = (SYNC_LEN == 1) ? LOCKED : LOCKING;

    state_e                state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [WIDTH-1:0]      expected_q, expected_d;
    logic                  locked_q, locked_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

`ifdef COUNTER_CHECK_CAPTURE_EN
    logic                  fe_valid_q, fe_valid_d;
    logic [WIDTH-1:0]      fe_exp_q, fe_exp_d;
    logic [WIDTH-1:0]      fe_obs_q, fe_obs_d;
`endif

    logic                  match;
    logic [WIDTH-1:0]      value_inc;

    assign match     = (value_i == expected_q);
    assign value_inc = value_i + 1'b1;   // wraps all-ones -> 0

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        expected_d  = expected_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
`ifdef COUNTER_CHECK_CAPTURE_EN
        fe_valid_d  = fe_valid_q;
        fe_exp_d    = fe_exp_q;
        fe_obs_d    = fe_obs_q;
`endif

        if (dut_reset_i) begin
            // Counter is being cleared: its next value is 0 and we trust it
            // immediately, so treat the clear as a full correct run.
            state_d    = LOCKED;
            run_d      = RUN_W'(SYNC_LEN);
            expected_d = '0;
        end else begin
            unique case (state_q)
                UNLOCKED: begin
                    expected_d = value_inc;
                    run_d      = RUN_W'(1);
                    state_d    = RESTART_ST;
                end
                LOCKING: begin
                    expected_d = value_inc;
                    if (match) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q + RUN_W'(1) == RUN_W'(SYNC_LEN)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        // Not yet locked: resynchronise silently.
                        run_d = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    expected_d = value_inc;
                    if (!match) begin
                        err_d   = 1'b1;
                        run_d   = RUN_W'(1);
                        state_d = RESTART_ST;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
`ifdef COUNTER_CHECK_CAPTURE_EN
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_exp_d   = expected_q;
                            fe_obs_d   = value_i;
                        end
`endif
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= UNLOCKED;
            run_q       <= '0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
`ifdef COUNTER_CHECK_CAPTURE_EN
            fe_valid_q  <= 1'b0;
            fe_exp_q    <= '0;
            fe_obs_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            expected_q  <= expected_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
`ifdef COUNTER_CHECK_CAPTURE_EN
            fe_valid_q  <= fe_valid_d;
            fe_exp_q    <= fe_exp_d;
            fe_obs_q    <= fe_obs_d;
`endif
        end
    end

    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;
    assign expected_o  = expected_q;
`ifdef COUNTER_CHECK_CAPTURE_EN
    assign first_err_valid_o = fe_valid_q;
    assign first_err_exp_o   = fe_exp_q;
    assign first_err_obs_o   = fe_obs_q;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//   Directed scenarios followed by a randomized run. Two checkers observe the
//   same stimulus: one with a 16-bit error counter, one with a 2-bit counter so
//   saturation is exercised. A behavioural model tracks what the checker should
//   report after every sampled clock edge.
// -----------------------------------------------------------------------------
module tb_counter_checker;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             dut_reset = 1'b0;

    logic             locked1, err1, locked2, err2;
    logic [15:0]      cnt1;
    logic [1:0]       cnt2;
    logic [WIDTH-1:0] exp1, exp2;
`ifdef COUNTER_CHECK_CAPTURE_EN
    logic             fev1, fev2;
    logic [WIDTH-1:0] fee1, feo1, fee2, feo2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(WIDTH), .ERR_CNT_W(16), .SYNC_LEN(SYNC)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .dut_reset_i(dut_reset),
`ifdef COUNTER_CHECK_CAPTURE_EN
        .first_err_valid_o(fev1), .first_err_exp_o(fee1), .first_err_obs_o(feo1),
`endif
        .locked_o(locked1), .err_o(err1), .err_count_o(cnt1), .expected_o(exp1)
    );

    counter_checker #(.WIDTH(WIDTH), .ERR_CNT_W(2), .SYNC_LEN(SYNC)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .dut_reset_i(dut_reset),
`ifdef COUNTER_CHECK_CAPTURE_EN
        .first_err_valid_o(fev2), .first_err_exp_o(fee2), .first_err_obs_o(feo2),
`endif
        .locked_o(locked2), .err_o(err2), .err_count_o(cnt2), .expected_o(exp2)
    );

    // ---------------- behavioural model ----------------
    bit m_seen;      // has any sample been taken since reset
    bit m_lock;
    bit m_err;
    int m_exp;
    int m_streak;    // consecutive correct samples, capped at SYNC
    int m_errs;      // total mismatches reported since reset
    bit m_fev;
    int m_fee, m_feo;

    task automatic model_reset();
        m_seen = 0; m_lock = 0; m_err = 0; m_exp = 0; m_streak = 0;
        m_errs = 0; m_fev = 0; m_fee = 0; m_feo = 0;
    endtask

    task automatic model_step(input int v, input bit dr);
        m_err = 0;
        if (dr) begin
            m_seen = 1; m_lock = 1; m_exp = 0; m_streak = SYNC;
        end else if (!m_seen) begin
            m_seen = 1; m_streak = 1; m_lock = (SYNC == 1); m_exp = (v + 1) % MOD;
        end else if (v == m_exp) begin
            m_streak = (m_streak + 1 > SYNC) ? SYNC : m_streak + 1;
            if (m_streak == SYNC) m_lock = 1;
            m_exp = (v + 1) % MOD;
        end else begin
            if (m_lock) begin
                m_err = 1;
                m_errs++;
                if (!m_fev) begin m_fev = 1; m_fee = m_exp; m_feo = v; end
            end
            m_streak = 1;
            m_lock = (SYNC == 1);
            m_exp = (v + 1) % MOD;
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic check_all(input string ph);
        chk({ph, " locked"},   32'(locked1), 32'(m_lock));
        chk({ph, " err"},      32'(err1),    32'(m_err));
        chk({ph, " err_count"}, 32'(cnt1),   32'(sat(m_errs, 65535)));
        chk({ph, " expected"}, 32'(exp1),    32'(m_exp));
        chk({ph, " err2"},     32'(err2),    32'(m_err));
        chk({ph, " err_count2"}, 32'(cnt2),  32'(sat(m_errs, 3)));
        chk({ph, " locked2"},  32'(locked2), 32'(m_lock));
        chk({ph, " expected2"}, 32'(exp2),   32'(m_exp));
`ifdef COUNTER_CHECK_CAPTURE_EN
        chk({ph, " fe_valid"}, 32'(fev1), 32'(m_fev));
        chk({ph, " fe_exp"},   32'(fee1), 32'(m_fee));
        chk({ph, " fe_obs"},   32'(feo1), 32'(m_feo));
`endif
    endtask

    // Present one sample, let the checker take it, then compare.
    task automatic step(input string ph, input int v, input bit dr);
        value = WIDTH'(v);
        dut_reset = dr;
        @(posedge clk);
        model_step(v, dr);
        #1;
        check_all(ph);
    endtask

    // Assert reset between clock edges and check outputs clear immediately.
    task automatic async_reset(input string ph, input int cycles);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all({ph, " async"});
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_all({ph, " held"});
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // 1: reset for 3 cycles, then a clean count locks after 2 samples
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all("t1 reset");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step("t1 count", i, 1'b0);
        chk("t1 locked after count", 32'(locked1), 32'd1);

        // 2: wrap from all-ones to 0 is a correct step
        async_reset("t2", 1);
        for (int v = 252; v < 259; v++) step("t2 wrap", v % MOD, 1'b0);
        chk("t2 no errors", 32'(cnt1), 32'd0);

        // 3: skip 12 -> single error, relock after next correct sample
        async_reset("t3", 1);
        step("t3", 8, 1'b0);  step("t3", 9, 1'b0);
        step("t3", 10, 1'b0); step("t3", 11, 1'b0);
        step("t3 skip", 13, 1'b0);
        chk("t3 err pulse", 32'(err1), 32'd1);
        chk("t3 unlocked", 32'(locked1), 32'd0);
        step("t3 relock", 14, 1'b0);
        chk("t3 err cleared", 32'(err1), 32'd0);
        chk("t3 relocked", 32'(locked1), 32'd1);
        step("t3", 15, 1'b0);
        chk("t3 count", 32'(cnt1), 32'd1);
`ifdef COUNTER_CHECK_CAPTURE_EN
        chk("t3 fe_exp const", 32'(fee1), 32'd12);
        chk("t3 fe_obs const", 32'(feo1), 32'd13);
`endif

        // 4: counter clears are not errors; a wrong value after clear is
        for (int v = 16; v <= 40; v++) step("t4 run", v, 1'b0);
        step("t4 dutrst", $urandom_range(0, MOD - 1), 1'b1);
        step("t4 dutrst", $urandom_range(0, MOD - 1), 1'b1);
        step("t4 post", 0, 1'b0); step("t4 post", 1, 1'b0);
        chk("t4 count unchanged", 32'(cnt1), 32'd1);
        step("t4 dutrst2", 40, 1'b1);
        step("t4 dutrst2", 40, 1'b1);
        step("t4 bad", 41, 1'b0);
        chk("t4 err after clear", 32'(err1), 32'd1);
        chk("t4 count inc", 32'(cnt1), 32'd2);

        // 5: five separated mismatches; 2-bit counter saturates at 3
        async_reset("t5", 1);
        step("t5", 0, 1'b0); step("t5", 1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step("t5 jump", 50 * (k + 1), 1'b0);
            step("t5 relock", 50 * (k + 1) + 1, 1'b0);
        end
        chk("t5 wide count", 32'(cnt1), 32'd5);
        chk("t5 sat count", 32'(cnt2), 32'd3);

        // 6: async reset while locked with errors pending
        step("t6", 7, 1'b0);
        async_reset("t6", 2);
        chk("t6 expected zero", 32'(exp1), 32'd0);

        // randomized run: mostly correct counting, some skips and clears
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5)       step("rnd", $urandom_range(0, MOD - 1), 1'b1);
            else if (r < 15) step("rnd", $urandom_range(0, MOD - 1), 1'b0);
            else             step("rnd", m_exp, 1'b0);
            if (c == 300) async_reset("rnd", 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
